// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, burst/response codes and slave state encoding
package axi_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_e;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_e;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_e;
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4 read/write channel bundle with master and slave views
interface axi_sram_slave_if;
  import axi_pkg::*;
  logic [ID_W-1:0] arid, awid, wid, rid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache;
  logic arvalid, arready, awvalid, awready;
  logic rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [STRB_W-1:0] wstrb;
  modport master(
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, rready, bready,
    input arready, awready, rid, rdata, rresp, rlast, rvalid, wready, bid, bresp, bvalid
  );
  modport slave(
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input wid, wdata, wstrb, wlast, wvalid, rready, bready,
    output arready, awready, rid, rdata, rresp, rlast, rvalid, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_beat_addr_gen.sv
// axi_beat_addr_gen: per-beat legality, SRAM word address and next beat address
module axi_beat_addr_gen import axi_pkg::*; #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int MEM_BYTES = 65536,
  localparam int SRAM_AW = $clog2(MEM_BYTES / 8)
) (
  input  logic [63:0] addr,
  input  logic [2:0] size,
  input  logic [1:0] burst,
  output logic [1:0] resp,
  output logic [SRAM_AW-1:0] word,
  output logic [63:0] addr_nx
);
  logic [63:0] off;
  // decode is pure combinational; decode errors outrank size/burst errors
  always_comb begin
    off = addr - BASE_ADDR;
    resp = (addr < BASE_ADDR || off >= 64'(MEM_BYTES)) ? DECERR : (size > 3'd3 || burst[1]) ? SLVERR : OKAY;
    word = off[3 +: SRAM_AW];
    addr_nx = burst == INCR ? addr + (64'd1 << size) : addr;
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-burst AXI4 slave in front of a single-port synchronous SRAM
module axi_sram_slave import axi_pkg::*; #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int MEM_BYTES = 65536,
  localparam int SRAM_AW = $clog2(MEM_BYTES / 8)
) (
  input  logic clock,
  input  logic resetn,
  axi_sram_slave_if.slave axi,
  output logic sram_en,
  output logic [7:0] sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [63:0] sram_wdata,
  input  logic [63:0] sram_rdata
);
  state_e state, state_nx;
  logic rd_prio, grant_r, grant_w, last_beat, r_hs, w_hs;
  logic [3:0] id;
  logic [63:0] addr, addr_nx;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic [1:0] burst, err, beat_resp;
  logic [SRAM_AW-1:0] word;

  axi_beat_addr_gen #(.BASE_ADDR(BASE_ADDR), .MEM_BYTES(MEM_BYTES)) u_gen (
    .addr, .size, .burst, .resp(beat_resp), .word, .addr_nx
  );

  assign grant_r = resetn && state == IDLE && axi.arvalid && (rd_prio || !axi.awvalid);
  assign grant_w = resetn && state == IDLE && axi.awvalid && !grant_r;
  assign last_beat = cnt == len;
  assign r_hs = state == RD_DATA && axi.rready;
  assign w_hs = state == WR_DATA && axi.wvalid;

  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;

  // next-state: one burst at a time, beat count rather than wlast ends writes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant_r ? RD_ADDR : grant_w ? WR_DATA : IDLE;
      RD_ADDR: state_nx = RD_DATA;
      RD_DATA: state_nx = !axi.rready ? RD_DATA : last_beat ? IDLE : RD_ADDR;
      WR_DATA: state_nx = (w_hs && last_beat) ? WR_RESP : WR_DATA;
      WR_RESP: state_nx = axi.bready ? IDLE : WR_RESP;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: everything gated by state so reset forces all of them to zero
  always_comb begin
    axi.arready = grant_r;
    axi.awready = grant_w;
    axi.rvalid = state == RD_DATA;
    axi.rid = axi.rvalid ? id : '0;
    axi.rresp = axi.rvalid ? beat_resp : OKAY;
    axi.rdata = (axi.rvalid && beat_resp == OKAY) ? sram_rdata : '0;
    axi.rlast = axi.rvalid && last_beat;
    axi.wready = state == WR_DATA;
    axi.bvalid = state == WR_RESP;
    axi.bid = axi.bvalid ? id : '0;
    axi.bresp = axi.bvalid ? err : OKAY;
    sram_en = beat_resp == OKAY && (state == RD_ADDR || (w_hs && axi.wstrb != '0));
    sram_we = (sram_en && state == WR_DATA) ? axi.wstrb : '0;
    sram_addr = sram_en ? word : '0;
    sram_wdata = sram_we != '0 ? axi.wdata : '0;
  end

  // burst context: latch on address grant, advance per beat, accumulate write errors
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      rd_prio <= 1'b1;
      id <= '0;
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      cnt <= '0;
      err <= OKAY;
    end else if (grant_r || grant_w) begin
      rd_prio <= grant_w;
      id <= grant_r ? axi.arid : axi.awid;
      addr <= grant_r ? axi.araddr : axi.awaddr;
      len <= grant_r ? axi.arlen : axi.awlen;
      size <= grant_r ? axi.arsize : axi.awsize;
      burst <= grant_r ? axi.arburst : axi.awburst;
      cnt <= '0;
      err <= OKAY;
    end else if (r_hs || w_hs) begin
      if (w_hs) err <= resp_max(err, resp_max(beat_resp, (axi.wlast != last_beat) ? SLVERR : OKAY));
      if (!last_beat) begin
        cnt <= cnt + 8'd1;
        addr <= addr_nx;
      end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed and randomized bursts checked against a memory/response model
module tb_axi_sram_slave;
  import axi_pkg::*;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int MEM_BYTES = 65536;
  localparam int WORDS = MEM_BYTES / 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  axi_sram_slave_if bus();
  logic sram_en;
  logic [7:0] sram_we;
  logic [12:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  axi_sram_slave #(.BASE_ADDR(BASE), .MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .resetn(resetn), .axi(bus), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  logic [63:0] mem [WORDS];
  int n_rd = 0;
  int n_wr = 0;
  // synchronous single-port SRAM; read data holds until the next access
  always @(posedge clock)
    if (sram_en) begin
      if (sram_we == 8'h00) begin
        sram_rdata <= mem[sram_addr];
        n_rd <= n_rd + 1;
      end else begin
        for (int i = 0; i < 8; i++) if (sram_we[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        n_wr <= n_wr + 1;
      end
    end

  logic [63:0] ref_mem [WORDS];
  logic [63:0] wd [64];
  logic [7:0] ws [64];
  logic [63:0] wl;
  int checks = 0;
  int errors = 0;
  int rd_base, wr_base;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] exp_resp(input logic [63:0] a, input logic [2:0] sz, input logic [1:0] bu);
    if (a < BASE || a >= BASE + 64'(MEM_BYTES)) return 2'd3;
    if (sz > 3'd3 || bu >= 2'd2) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [63:0] advance(input logic [63:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return bu == 2'd1 ? a + (64'd1 << sz) : a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_w(input int len, input bit bad_last);
    for (int b = 0; b <= len; b++) begin
      wd[b] = {$urandom, $urandom};
      ws[b] = 8'($urandom);
      wl[b] = (b == len);
    end
    if (bad_last) wl = {$urandom, $urandom};
  endtask

  // all tasks start and end just after a falling edge
  task automatic send_ar(input logic [3:0] id, input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu);
    int t = 0;
    rd_base = n_rd;
    bus.arid = id; bus.araddr = a; bus.arlen = 8'(len); bus.arsize = sz; bus.arburst = bu; bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && t < 50) begin @(negedge clock); #1; t++; end
    chk("ar_ready", bus.arready, 1);
    @(posedge clock);
    @(negedge clock);
    bus.arvalid = 1'b0;
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu);
    int t = 0;
    bus.awid = id; bus.awaddr = a; bus.awlen = 8'(len); bus.awsize = sz; bus.awburst = bu; bus.awvalid = 1'b1;
    #1;
    while (!bus.awready && t < 50) begin @(negedge clock); #1; t++; end
    chk("aw_ready", bus.awready, 1);
    @(posedge clock);
    @(negedge clock);
    bus.awvalid = 1'b0;
    wr_base = n_wr;
    #1;
  endtask

  // mode 0: rready high, 1: toggles every cycle, 2: random
  task automatic collect_r(input logic [3:0] id, input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu, input int mode);
    logic [63:0] ea = a;
    logic [63:0] ed;
    logic [1:0] er;
    int b = 0;
    int t = 0;
    int okc = 0;
    bus.rready = (mode != 1);
    while (b <= len && t < 200) begin
      if (bus.rvalid) begin
        er = exp_resp(ea, sz, bu);
        ed = 64'd0;
        if (er == 2'd0) ed = ref_mem[(ea - BASE) >> 3];
        chk("rresp", bus.rresp, er);
        chk("rdata", bus.rdata, ed);
        chk("rlast", bus.rlast, b == len);
        chk("rid", bus.rid, id);
        if (bus.rready) begin
          b++;
          if (er == 2'd0) okc++;
          ea = advance(ea, sz, bu);
        end
      end
      @(negedge clock);
      #1;
      bus.rready = mode == 0 ? 1'b1 : mode == 1 ? ~bus.rready : 1'($urandom_range(0, 1));
      t++;
    end
    bus.rready = 1'b0;
    chk("r_beats", b, len + 1);
    chk("sram_reads", n_rd - rd_base, okc);
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu);
    logic [63:0] ea = a;
    logic [1:0] er;
    logic [1:0] acc = 2'd0;
    int nw = 0;
    int t;
    send_aw(id, a, len, sz, bu);
    for (int b = 0; b <= len; b++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = wl[b];
      #1;
      t = 0;
      while (!bus.wready && t < 50) begin @(negedge clock); #1; t++; end
      chk("w_ready", bus.wready, 1);
      er = exp_resp(ea, sz, bu);
      chk("sram_we", sram_we, er == 2'd0 ? ws[b] : 8'h00);
      if (er == 2'd0 && ws[b] != 8'h00) begin
        nw++;
        for (int i = 0; i < 8; i++) if (ws[b][i]) ref_mem[(ea - BASE) >> 3][8*i +: 8] = wd[b][8*i +: 8];
      end
      if (er > acc) acc = er;
      if (wl[b] != (b == len) && acc < 2'd2) acc = 2'd2;
      ea = advance(ea, sz, bu);
      @(posedge clock);
      @(negedge clock);
      #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    #1;
    chk("w_ready_after", bus.wready, 0);
    t = 0;
    while (!bus.bvalid && t < 50) begin @(negedge clock); #1; t++; end
    repeat ($urandom_range(0, 2)) begin
      chk("bvalid_hold", bus.bvalid, 1);
      @(negedge clock);
      #1;
    end
    chk("bvalid", bus.bvalid, 1);
    chk("bresp", bus.bresp, acc);
    chk("bid", bus.bid, id);
    bus.bready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.bready = 1'b0;
    #1;
    chk("bvalid_drop", bus.bvalid, 0);
    chk("sram_writes", n_wr - wr_base, nw);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 64'd0;
    {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot} = '0;
    {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot} = '0;
    {bus.wid, bus.wdata, bus.wstrb, bus.wlast, bus.wvalid, bus.rready, bus.bready} = '0;
    bus.arvalid = 1'b1;
    bus.awvalid = 1'b1;
    #1;
    chk("rst_arready", bus.arready, 0);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_addr", sram_addr, 0);
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    #1;

    fill_w(63, 0);
    for (int b = 0; b <= 63; b++) ws[b] = 8'hff;
    wr_burst(4'd1, BASE, 63, 3'd3, 2'd1);
    fill_w(3, 0);
    for (int b = 0; b <= 3; b++) ws[b] = 8'hff;
    wr_burst(4'd2, BASE + 64'((WORDS - 4) * 8), 3, 3'd3, 2'd1);

    wd[0] = 64'h1122334455667788; ws[0] = 8'hff; wl = 64'd1;
    wr_burst(4'd0, BASE + 64'h10, 0, 3'd3, 2'd0);
    send_ar(4'd3, BASE + 64'h10, 0, 3'd3, 2'd0);
    chk("t1_sram_en", sram_en, 1);
    chk("t1_sram_addr", sram_addr, 2);
    chk("t1_rvalid_early", bus.rvalid, 0);
    @(negedge clock);
    #1;
    chk("t1_rvalid", bus.rvalid, 1);
    chk("t1_rdata", bus.rdata, 64'h1122334455667788);
    collect_r(4'd3, BASE + 64'h10, 0, 3'd3, 2'd0, 0);

    wd[0] = 64'hAA << 24; ws[0] = 8'h08; wl = 64'd1;
    wr_burst(4'd5, BASE + 64'h3, 0, 3'd0, 2'd0);
    send_ar(4'd6, BASE, 0, 3'd3, 2'd1);
    collect_r(4'd6, BASE, 0, 3'd3, 2'd1, 0);

    send_ar(4'd7, BASE + 64'h100, 3, 3'd3, 2'd1);
    collect_r(4'd7, BASE + 64'h100, 3, 3'd3, 2'd1, 1);

    send_ar(4'd8, 64'h1000, 0, 3'd3, 2'd1);
    chk("t4_no_sram_en", sram_en, 0);
    collect_r(4'd8, 64'h1000, 0, 3'd3, 2'd1, 0);
    fill_w(0, 0);
    ws[0] = 8'hff;
    wr_burst(4'd9, BASE + 64'h1_0000, 0, 3'd3, 2'd1);

    for (int k = 0; k < 24; k++) begin
      logic [63:0] a;
      int ln, r;
      logic [2:0] sz;
      logic [1:0] bu;
      logic [3:0] id;
      r = $urandom_range(0, 7);
      a = r == 0 ? BASE + 64'((WORDS - 2) * 8) : r == 1 ? BASE - 64'd8 : BASE + 64'($urandom_range(0, 59) * 8);
      ln = $urandom_range(0, 3);
      r = $urandom_range(0, 4);
      sz = r == 0 ? 3'd2 : r == 1 ? 3'd5 : 3'd3;
      bu = $urandom_range(0, 7) == 0 ? 2'd2 : 2'($urandom_range(0, 1));
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        fill_w(ln, $urandom_range(0, 4) == 0);
        wr_burst(id, a, ln, sz, bu);
      end else begin
        send_ar(id, a, ln, sz, bu);
        collect_r(id, a, ln, sz, bu, $urandom_range(0, 2));
      end
    end

    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    bus.araddr = BASE + 64'h20; bus.arid = 4'd10; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = 2'd1; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 64'h28; bus.awid = 4'd11; bus.awlen = 8'd1; bus.awsize = 3'd3; bus.awburst = 2'd1; bus.awvalid = 1'b1;
    #1;
    chk("t5_arready", bus.arready, 1);
    chk("t5_awready", bus.awready, 0);
    rd_base = n_rd;
    @(posedge clock);
    @(negedge clock);
    bus.arvalid = 1'b0;
    #1;
    chk("t5_aw_waits", bus.awready, 0);
    collect_r(4'd10, BASE + 64'h20, 0, 3'd3, 2'd1, 0);
    fill_w(1, 0);
    ws[0] = 8'hff; ws[1] = 8'hff; wl = 64'd1;
    wr_burst(4'd11, BASE + 64'h28, 1, 3'd3, 2'd1);
    send_ar(4'd12, BASE + 64'h28, 1, 3'd3, 2'd1);
    collect_r(4'd12, BASE + 64'h28, 1, 3'd3, 2'd1, 0);

    send_ar(4'd13, BASE + 64'h40, 0, 3'd3, 2'd1);
    @(negedge clock);
    #1;
    chk("t6_rvalid_before", bus.rvalid, 1);
    resetn = 1'b0;
    #1;
    chk("t6_rvalid", bus.rvalid, 0);
    chk("t6_rdata", bus.rdata, 0);
    chk("t6_rid", bus.rid, 0);
    chk("t6_sram_en", sram_en, 0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("t6_idle_rvalid", bus.rvalid, 0);
    send_ar(4'd14, BASE + 64'h48, 2, 3'd3, 2'd1);
    collect_r(4'd14, BASE + 64'h48, 2, 3'd3, 2'd1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI4 slave (responder) in front of a single-port synchronous SRAM. It is the memory-side end of the CPU's sram-like-to-AXI master bridge. It accepts one read or write burst at a time, turns each beat into an SRAM access, and returns R/B responses. It serves as on-chip RAM and as the bench memory for the master bridge.

Parameters:
BASE_ADDR, 64'h8000_0000, first decoded byte address
MEM_BYTES, 65536, decoded size in bytes; power of two, at least 8
SRAM_AW, $clog2(MEM_BYTES/8), SRAM word-address width; derived, never overridden

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous, active-low reset
arid/awid  input  4  transaction ID
araddr/awaddr  input  64  start byte address
arlen/awlen  input  8  beats minus 1
arsize/awsize  input  3  log2(bytes per beat)
arburst/awburst  input  2  0 FIXED, 1 INCR, 2/3 unsupported
arlock/awlock, arcache/awcache, arprot/awprot, wid  input  2/4/3/4  accepted, ignored
arvalid/awvalid  input  1  address valid
arready/awready  output  1  address ready
rid  output  4  latched arid
rdata  output  64  read data
rresp  output  2  per-beat response
rlast  output  1  final read beat
rvalid  output  1  read data valid
rready  input  1  read data ready
wdata  input  64  write data
wstrb  input  8  byte-lane strobes
wlast  input  1  master's final-beat flag
wvalid  input  1  write data valid
wready  output  1  write data ready
bid  output  4  latched awid
bresp  output  2  burst write response
bvalid  output  1  response valid
bready  input  1  response ready
sram_en  output  1  access strobe
sram_we  output  8  byte write enables; 0 means read
sram_addr  output  SRAM_AW  word address
sram_wdata  output  64  write data
sram_rdata  input  64  valid the cycle after a read strobe; held until the next sram_en

Behaviour:
- Reset: resetn=0 takes effect immediately (asynchronous).
  - State goes to IDLE and the arbitration pointer goes to "read".
  - All outputs go to 0 (arready, awready, wready, rvalid, rlast, rid, rresp, rdata, bvalid, bid, bresp, sram_en, sram_we, sram_addr, sram_wdata).
  - A burst in progress is abandoned and no response is issued.
- States: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP. One burst in flight at a time; no outstanding queue.
- IDLE:
  - arready and awready are combinational from the valids; at most one is granted.
  - If both valids are high, the grant goes to the channel not served last; first grant after reset is read.
  - On the handshake, latch id, addr, len, size and burst; clear the beat count and the error accumulator. Next state is RD_ADDR or WR_DATA.
- Beat legality, evaluated per beat:
  - DECERR if addr < BASE_ADDR or addr >= BASE_ADDR+MEM_BYTES.
  - Otherwise SLVERR if size > 3 or burst is 2 or 3.
  - Otherwise OKAY.
  - Non-OKAY beats never assert sram_en.
  - sram_addr = (addr - BASE_ADDR) >> 3.
- Address advance after each beat: INCR adds 1<<size (64-bit wrap, no 4KB check). FIXED and unsupported bursts keep the address.
- RD_ADDR (one cycle): sram_en=1 and sram_we=0 if the beat is legal; then RD_DATA.
- RD_DATA:
  - rvalid=1; rdata = sram_rdata if OKAY, else 0; rresp = beat legality; rlast = (count==len).
  - All R outputs hold stable while rready=0.
  - On handshake: if rlast, go to IDLE; otherwise increment count, advance addr, go to RD_ADDR.
  - AR handshake at edge n gives rvalid high in cycle n+2. Maximum rate is 1 beat per 2 cycles.
- WR_DATA:
  - wready=1.
  - On handshake, in the same cycle: sram_en = legal && wstrb!=0, sram_we = wstrb, sram_wdata = wdata.
  - The error accumulator keeps the worst result, DECERR over SLVERR over OKAY. A mismatch of wlast against (count==len) contributes SLVERR.
  - The beat count, not wlast, ends the burst. After the final beat go to WR_RESP; otherwise increment count and advance addr.
- W beats arriving before the AW handshake wait; wready is 0 outside WR_DATA.
- WR_RESP: bvalid=1, bresp = accumulator, bid = latched awid. Hold until bready, then go to IDLE.
- No cycle issues both a read and a write to the SRAM.

Decomposition:
- Shared package axi_pkg, also used by the master bridge, holds:
  - burst codes FIXED/INCR/WRAP;
  - resp codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - ID/addr/data/strb widths 4/64/64/8;
  - the state enum.
- One sub-module, axi_beat_addr_gen (addr, size, burst -> legality, sram word address, next addr), instantiated once and shared by the read and write paths.

Test Plan:
1. Preload word 0x8000_0010 = 0x1122334455667788, then AR(id 3, addr 0x8000_0010, len 0, size 3, FIXED) -> rvalid two cycles after the handshake with rdata 0x1122334455667788, rid 3, rresp 0, rlast 1.
2. AW(addr 0x8000_0003, size 0), W(wdata 0xAA<<24, wstrb 0x08, wlast 1) -> exactly one sram_we=0x08, then bresp 0 with bid echoed; readback changes only byte 3.
3. INCR, len 3, size 3, from 0x8000_0100, with rready toggling every cycle -> 4 beats from words 0x20..0x23, rlast only on beat 4, R outputs stable during stalls.
4. Read at 0x0000_1000 -> rresp 3, rdata 0, sram_en never high. Write at 0x8001_0000 -> bresp 3, no SRAM write.
5. arvalid and awvalid asserted together after reset -> read served first, then write. A 2-beat write with wlast on beat 1 -> both beats written, bresp 2.
6. resetn low during RD_DATA with rready=0 -> rvalid and sram_en drop immediately. After release a new read completes normally.
